// File: rtl/indicator_panel_rx_pkg.sv
// Shared constants and frame-boundary classification for the QSIC indicator-panel receiver.
// Frame geometry is shared with the panel driver in the QSIC top.
package indicator_panel_rx_pkg;

   localparam int IP_ROWS       = 4;
   localparam int IP_ROW_BITS   = 36;
   localparam int IP_FRAME_BITS = IP_ROWS * IP_ROW_BITS;

   // Outcome of a frame marker for the frame that just ended
   typedef enum logic [1:0] {
      FC_NONE   = 2'd0,
      FC_COMMIT = 2'd1,
      FC_ERROR  = 2'd2
   } frame_chk_e;

   // A marker only judges the previous frame once the receiver has locked onto a boundary
   function automatic frame_chk_e frame_check(input logic synced,
                                              input logic cnt_full,
                                              input logic overrun);
      frame_chk_e res;
      if (!synced) begin
         res = FC_NONE;
      end else if (cnt_full && !overrun) begin
         res = FC_COMMIT;
      end else begin
         res = FC_ERROR;
      end
      return res;
   endfunction

endpackage

// File: rtl/indicator_panel_rx_sync_edge.sv
// sync_edge: two-flop synchronizer plus history flop for one asynchronous link line.
// o_level is the history-stage level and o_rise the registered rising pulse, so the
// level of every line and the ip_clk rise pulse line up on the same cycle.
module sync_edge (
   input  logic clk20,
   input  logic reset,
   input  logic i_d,
   output logic o_level,
   output logic o_rise
);

   logic r_meta;
   logic r_sync;
   logic r_hist;
   logic r_rise;

   // Resynchronize the line, keep one cycle of history and register the rising edge
   always_ff @(posedge clk20) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_hist <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
         r_hist <= r_sync;
         r_rise <= r_sync & ~r_hist;
      end
   end

   assign o_level = r_hist;
   assign o_rise  = r_rise;

endmodule

// File: rtl/indicator_panel_rx.sv
// indicator_panel_rx: panel-side receiver for the QSIC indicator-panel serial link.
// Deserializes latch-delimited frames, commits complete frames to the lamp register
// and counts malformed frames with a saturating counter.
// Optional feature macro IP_WATCHDOG_EN: link watchdog that blanks the lamps and raises
// link_lost after WDOG_CYCLES clk20 cycles without an ip_clk rise.
module indicator_panel_rx
   import indicator_panel_rx_pkg::*;
#(
   parameter int FRAME_BITS = IP_FRAME_BITS,
   parameter int ERR_W      = 8
`ifdef IP_WATCHDOG_EN
   , parameter int WDOG_CYCLES = 4096
`endif
) (
   input  logic                  clk20,
   input  logic                  reset,
   input  logic                  ip_clk,
   input  logic                  ip_latch,
   input  logic                  ip_out,
   output logic [FRAME_BITS-1:0] lamps,
   output logic                  frame_valid,
   output logic                  frame_done,
   output logic                  frame_err,
   output logic [ERR_W-1:0]      err_count,
   output logic                  link_lost
);

   localparam int              CNT_W    = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

   logic w_clk_rise;
   logic w_clk_lvl;
   logic w_latch_lvl;
   logic w_latch_rise;
   logic w_out_lvl;
   logic w_out_rise;
   logic w_unused;

   logic [FRAME_BITS-1:0] r_shift;
   logic [FRAME_BITS-1:0] r_lamps;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [ERR_W-1:0]      r_err_count;
   logic                  r_synced;
   logic                  r_overrun;
   logic                  r_valid;
   logic                  r_done;
   logic                  r_err;

   frame_chk_e w_chk;

   sync_edge u_sync_clk (
      .clk20   (clk20),
      .reset   (reset),
      .i_d     (ip_clk),
      .o_level (w_clk_lvl),
      .o_rise  (w_clk_rise)
   );

   sync_edge u_sync_latch (
      .clk20   (clk20),
      .reset   (reset),
      .i_d     (ip_latch),
      .o_level (w_latch_lvl),
      .o_rise  (w_latch_rise)
   );

   sync_edge u_sync_out (
      .clk20   (clk20),
      .reset   (reset),
      .i_d     (ip_out),
      .o_level (w_out_lvl),
      .o_rise  (w_out_rise)
   );

   // Only the ip_clk edge and the latch/data levels drive the frame logic
   assign w_unused = w_clk_lvl ^ w_latch_rise ^ w_out_rise;

   // Judgement of the frame that a marker closes, from state before the marker
   assign w_chk = frame_check(r_synced, (r_bit_cnt == CNT_FULL), r_overrun);

`ifdef IP_WATCHDOG_EN
   localparam int              WD_W    = $clog2(WDOG_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

   logic [WD_W-1:0] r_wdog;
   logic            r_link_lost;
`endif

   // Frame deserializer, lamp commit, error counting and (optionally) the link watchdog
   always_ff @(posedge clk20) begin
      if (reset) begin
         r_shift     <= '0;
         r_lamps     <= '0;
         r_bit_cnt   <= '0;
         r_err_count <= '0;
         r_synced    <= 1'b0;
         r_overrun   <= 1'b0;
         r_valid     <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
`ifdef IP_WATCHDOG_EN
         r_wdog      <= '0;
         r_link_lost <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (w_clk_rise) begin
`ifdef IP_WATCHDOG_EN
            r_wdog <= '0;
`endif
            if (w_latch_lvl) begin
               case (w_chk)
                  FC_COMMIT: begin
                     r_lamps <= r_shift;
                     r_done  <= 1'b1;
                     r_valid <= 1'b1;
`ifdef IP_WATCHDOG_EN
                     r_link_lost <= 1'b0;
`endif
                  end
                  FC_ERROR: begin
                     r_err <= 1'b1;
                     if (r_err_count != '1) begin
                        r_err_count <= r_err_count + ERR_ONE;
                     end
                  end
                  default: begin
                  end
               endcase
               // The marker bit is bit 0 of the new frame
               r_shift   <= {r_shift[FRAME_BITS-2:0], w_out_lvl};
               r_bit_cnt <= CNT_ONE;
               r_overrun <= 1'b0;
               r_synced  <= 1'b1;
            end else if (r_synced) begin
               if (r_bit_cnt < CNT_FULL) begin
                  r_shift   <= {r_shift[FRAME_BITS-2:0], w_out_lvl};
                  r_bit_cnt <= r_bit_cnt + CNT_ONE;
               end else begin
                  // Excess bits are dropped; the frame is rejected at its closing marker
                  r_overrun <= 1'b1;
               end
            end
`ifdef IP_WATCHDOG_EN
         end else if (r_wdog != WD_MAX) begin
            r_wdog <= r_wdog + WD_ONE;
            if (r_wdog == WD_LAST) begin
               // Link silent: blank the panel and wait for a fresh marker to resync
               r_link_lost <= 1'b1;
               r_lamps     <= '0;
               r_valid     <= 1'b0;
               r_synced    <= 1'b0;
            end
`endif
         end
      end
   end

   assign lamps       = r_lamps;
   assign frame_valid = r_valid;
   assign frame_done  = r_done;
   assign frame_err   = r_err;
   assign err_count   = r_err_count;
`ifdef IP_WATCHDOG_EN
   assign link_lost   = r_link_lost;
`else
   assign link_lost   = 1'b0;
`endif

endmodule

// File: tb/tb_indicator_panel_rx.sv
// Self-checking bench for indicator_panel_rx: frame-level scoreboard of commits and
// discards plus per-scenario register checks. Define IP_WATCHDOG_EN to exercise the watchdog.
module tb_indicator_panel_rx;

   localparam int FB = 144;

   logic          clk20;
   logic          reset;
   logic          ip_clk;
   logic          ip_latch;
   logic          ip_out;
   logic [FB-1:0] lamps;
   logic          frame_valid;
   logic          frame_done;
   logic          frame_err;
   logic [7:0]    err_count;
   logic          link_lost;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          is_err;
      logic [FB-1:0] lamps;
   } exp_t;

   exp_t sb_q[$];

   localparam logic [FB-1:0] P_A5 = {18{8'hA5}};
   localparam logic [FB-1:0] P_3C = {18{8'h3C}};
   localparam logic [FB-1:0] P_BE = {9{16'hBEEF}};
   localparam logic [FB-1:0] P_91 = {4{36'h9_1234_5678}};
   localparam logic [FB-1:0] P_0F = {18{8'h0F}};
   localparam logic [FB-1:0] P_C7 = {4{36'hC_0FFE_E123}};
   localparam logic [FB-1:0] P_55 = {18{8'h55}};
   localparam logic [FB-1:0] P_E1 = {9{16'hE1D2}};
   localparam logic [FB-1:0] P_7B = {4{36'h7_B00B_1E55}};

   indicator_panel_rx #(
      .FRAME_BITS (FB),
      .ERR_W      (8)
`ifdef IP_WATCHDOG_EN
      , .WDOG_CYCLES (100)
`endif
   ) dut (
      .clk20       (clk20),
      .reset       (reset),
      .ip_clk      (ip_clk),
      .ip_latch    (ip_latch),
      .ip_out      (ip_out),
      .lamps       (lamps),
      .frame_valid (frame_valid),
      .frame_done  (frame_done),
      .frame_err   (frame_err),
      .err_count   (err_count),
      .link_lost   (link_lost)
   );

   initial clk20 = 1'b0;
   always #5 clk20 = ~clk20;

   // Scoreboard: every commit/discard pulse must match the oldest expected frame outcome
   always @(negedge clk20) begin
      exp_t e;
      if (frame_done || frame_err) begin
         checks++;
         if (frame_done && frame_err) begin
            errors++;
            $display("FAIL pulse_exclusive: done=%b err=%b, required not both", frame_done, frame_err);
         end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: done=%b err=%b, required no event", frame_done, frame_err);
         end else begin
            e = sb_q.pop_front();
            if (frame_err !== e.is_err) begin
               errors++;
               $display("FAIL event_kind: err=%b, required err=%b", frame_err, e.is_err);
            end else if (!e.is_err && (lamps !== e.lamps)) begin
               errors++;
               $display("FAIL commit_lamps: got %h, required %h", lamps, e.lamps);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk20);
      #1;
   endtask

   task automatic push_done(input logic [FB-1:0] p);
      exp_t e;
      e.is_err = 1'b0;
      e.lamps  = p;
      sb_q.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.is_err = 1'b1;
      e.lamps  = '0;
      sb_q.push_back(e);
   endtask

   // One link bit: data set up while ip_clk is low, 4 clk20 high, 4 clk20 low
   task automatic send_bit(input logic l, input logic d);
      ip_latch = l;
      ip_out   = d;
      tick(2);
      ip_clk = 1'b1;
      tick(4);
      ip_clk = 1'b0;
      tick(2);
   endtask

   // n bits starting with the marker bit; first bit is p[FB-1]; bits past FB are zero
   task automatic send_frame(input logic [FB-1:0] p, input int n);
      for (int i = 0; i < n; i++) begin
         send_bit((i == 0), (i < FB) ? p[FB-1-i] : 1'b0);
      end
      ip_latch = 1'b0;
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < 100) begin
         tick(1);
         k++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d events outstanding, required 0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic check_outputs_zero(input string name);
      checks++;
      if ({lamps, frame_valid, frame_done, frame_err, err_count, link_lost} !== '0) begin
         errors++;
         $display("FAIL %s: lamps=%h valid=%b done=%b err=%b cnt=%0d lost=%b, required all 0",
                  name, lamps, frame_valid, frame_done, frame_err, err_count, link_lost);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(4);
      check_outputs_zero("reset_state");
      reset = 1'b0;
      tick(2);
      check_outputs_zero("after_reset");
   endtask

   task automatic test_good_frames();
      send_frame(P_A5, FB);
      tick(6);
      checks++;
      if (frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL first_marker_valid: got %b, required 0", frame_valid);
      end
      push_done(P_A5);
      send_frame(P_A5, FB);
      drain("good");
      checks++;
      if (lamps !== P_A5) begin
         errors++;
         $display("FAIL good_lamps: got %h, required %h", lamps, P_A5);
      end
      checks++;
      if (frame_valid !== 1'b1 || err_count !== 8'd0) begin
         errors++;
         $display("FAIL good_status: valid=%b cnt=%0d, required valid=1 cnt=0", frame_valid, err_count);
      end
   endtask

   task automatic test_short_frame();
      push_done(P_A5);
      send_frame(P_3C, FB - 1);
      push_err();
      send_frame(P_BE, FB);
      drain("short");
      checks++;
      if (err_count !== 8'd1) begin
         errors++;
         $display("FAIL short_count: got %0d, required 1", err_count);
      end
      checks++;
      if (lamps !== P_A5) begin
         errors++;
         $display("FAIL short_lamps_hold: got %h, required %h", lamps, P_A5);
      end
   endtask

   task automatic test_overrun();
      push_done(P_BE);
      send_frame(P_91, 150);
      drain("overrun_a");
      checks++;
      if (err_count !== 8'd1 || lamps !== P_BE) begin
         errors++;
         $display("FAIL overrun_pending: cnt=%0d lamps=%h, required cnt=1 lamps=%h", err_count, lamps, P_BE);
      end
      push_err();
      send_frame(P_0F, FB);
      push_done(P_0F);
      send_bit(1'b1, 1'b0);
      drain("overrun_b");
      checks++;
      if (err_count !== 8'd2 || lamps !== P_0F) begin
         errors++;
         $display("FAIL overrun_recover: cnt=%0d lamps=%h, required cnt=2 lamps=%h", err_count, lamps, P_0F);
      end
   endtask

   task automatic test_err_saturate();
      for (int i = 0; i < 300; i++) begin
         push_err();
         send_bit(1'b1, i[0]);
      end
      drain("saturate");
      checks++;
      if (err_count !== 8'd255) begin
         errors++;
         $display("FAIL err_saturate: got %0d, required 255", err_count);
      end
      push_err();
      send_frame(P_C7, 70);
      drain("saturate_hold");
      checks++;
      if (err_count !== 8'd255 || lamps !== P_0F) begin
         errors++;
         $display("FAIL saturate_hold: cnt=%0d lamps=%h, required cnt=255 lamps=%h", err_count, lamps, P_0F);
      end
   endtask

   task automatic test_reset_midframe();
      reset = 1'b1;
      tick(3);
      check_outputs_zero("midframe_reset");
      reset = 1'b0;
      tick(2);
      send_frame(P_55, FB);
      push_done(P_55);
      send_frame(P_E1, FB);
      drain("post_reset");
      checks++;
      if (lamps !== P_55 || err_count !== 8'd0 || frame_valid !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_commit: lamps=%h cnt=%0d valid=%b, required lamps=%h cnt=0 valid=1",
                  lamps, err_count, frame_valid, P_55);
      end
      push_done(P_E1);
      send_bit(1'b1, 1'b1);
      drain("post_reset_b");
   endtask

   task automatic test_watchdog();
`ifdef IP_WATCHDOG_EN
      int k;
      tick(80);
      checks++;
      if (link_lost !== 1'b0) begin
         errors++;
         $display("FAIL wdog_early: link_lost=%b, required 0", link_lost);
      end
      k = 0;
      while (link_lost !== 1'b1 && k < 200) begin
         tick(1);
         k++;
      end
      checks++;
      if (link_lost !== 1'b1 || lamps !== '0 || frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL wdog_expire: lost=%b lamps=%h valid=%b, required lost=1 lamps=0 valid=0",
                  link_lost, lamps, frame_valid);
      end
      send_frame(P_7B, FB);
      tick(6);
      checks++;
      if (link_lost !== 1'b1) begin
         errors++;
         $display("FAIL wdog_first_marker: link_lost=%b, required 1", link_lost);
      end
      push_done(P_7B);
      send_bit(1'b1, 1'b0);
      drain("wdog_resume");
      checks++;
      if (link_lost !== 1'b0 || lamps !== P_7B) begin
         errors++;
         $display("FAIL wdog_resume: lost=%b lamps=%h, required lost=0 lamps=%h", link_lost, lamps, P_7B);
      end
`else
      tick(300);
      checks++;
      if (link_lost !== 1'b0 || lamps !== P_E1 || frame_valid !== 1'b1) begin
         errors++;
         $display("FAIL idle_hold: lost=%b lamps=%h valid=%b, required lost=0 lamps=%h valid=1",
                  link_lost, lamps, frame_valid, P_E1);
      end
`endif
   endtask

   initial begin
      reset    = 1'b1;
      ip_clk   = 1'b0;
      ip_latch = 1'b0;
      ip_out   = 1'b0;
      test_reset();
      test_good_frames();
      test_short_frame();
      test_overrun();
      test_err_saturate();
      test_reset_midframe();
      test_watchdog();
      tick(10);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
